// File: rtl/gate_actuator_ctrl.sv
// Boom-gate actuator responder: sequences the warning lamp and motor travel on the
// monitor's close request, supervises limit switches and travel time, reports status.
module gate_actuator_ctrl #(
  parameter int WARN_CYCLES    = 300_000_000,
  parameter int TRAVEL_TIMEOUT = 800_000_000,
  parameter int BLINK_HALF     = 50_000_000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic close_req,
  input  logic limit_down,
  input  logic limit_up,
  output logic motor_down,
  output logic motor_up,
  output logic warn_lamp,
  output logic gate_closed,
  output logic gate_open,
  output logic fault
);

  localparam int WARN_W   = $clog2(WARN_CYCLES) + 1;
  localparam int TRAVEL_W = $clog2(TRAVEL_TIMEOUT) + 1;
  localparam int BLINK_W  = $clog2(BLINK_HALF) + 1;

  localparam logic [WARN_W-1:0]   WARN_LAST   = WARN_W'(WARN_CYCLES - 1);
  localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_TIMEOUT - 1);
  localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_HALF - 1);

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_OPEN     = 3'd1,
    S_WARN     = 3'd2,
    S_LOWERING = 3'd3,
    S_CLOSED   = 3'd4,
    S_RAISING  = 3'd5,
    S_REVERSE  = 3'd6,
    S_FAULT    = 3'd7
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_close_sync;
  logic [1:0]           r_down_sync;
  logic [1:0]           r_up_sync;
  logic                 w_close_s;
  logic                 w_down_s;
  logic                 w_up_s;
  logic [WARN_W-1:0]    r_warn_cnt;
  logic [TRAVEL_W-1:0]  r_travel_cnt;
  logic [BLINK_W-1:0]   r_blink_cnt;
  logic [BLINK_W-1:0]   w_blink_cnt;
  logic                 r_blink_phase;
  logic                 w_blink_phase;
  logic                 w_travel_expired;

  function automatic logic is_blink(input state_t s);
    is_blink = (s == S_WARN) || (s == S_LOWERING) || (s == S_CLOSED) ||
               (s == S_RAISING) || (s == S_REVERSE);
  endfunction

  // Synchronisers stay out of reset so INIT sees the true switch levels as reset lifts.
  always_ff @(posedge clk_100MHz) begin
    r_close_sync <= {r_close_sync[0], close_req};
    r_down_sync  <= {r_down_sync[0], limit_down};
    r_up_sync    <= {r_up_sync[0], limit_up};
  end

  assign w_close_s        = r_close_sync[1];
  assign w_down_s         = r_down_sync[1];
  assign w_up_s           = r_up_sync[1];
  assign w_travel_expired = (r_travel_cnt == TRAVEL_LAST);

  // Next-state selection; a limit-switch conflict overrides every other transition.
  always_comb begin
    w_next = r_state;
    if ((r_state != S_INIT) && w_up_s && w_down_s) begin
      w_next = S_FAULT;
    end else begin
      case (r_state)
        S_INIT:     w_next = w_up_s ? S_OPEN : S_RAISING;
        S_OPEN:     w_next = w_close_s ? S_WARN : S_OPEN;
        S_WARN: begin
          if (!w_close_s) begin
            w_next = S_OPEN;
          end else if (r_warn_cnt == WARN_LAST) begin
            w_next = S_LOWERING;
          end else begin
            w_next = S_WARN;
          end
        end
        S_LOWERING: begin
          if (w_down_s) begin
            w_next = S_CLOSED;
          end else if (w_travel_expired) begin
            w_next = S_FAULT;
          end else begin
            w_next = S_LOWERING;
          end
        end
        S_CLOSED:   w_next = w_close_s ? S_CLOSED : S_RAISING;
        S_RAISING: begin
          if (w_close_s) begin
            w_next = S_REVERSE;
          end else if (w_up_s) begin
            w_next = S_OPEN;
          end else if (w_travel_expired) begin
            w_next = S_FAULT;
          end else begin
            w_next = S_RAISING;
          end
        end
        S_REVERSE:  w_next = S_LOWERING;
        S_FAULT:    w_next = S_FAULT;
        default:    w_next = S_FAULT;
      endcase
    end
  end

  // Lamp phase starts lit when the blinking states are entered and runs on across them.
  always_comb begin
    w_blink_cnt   = r_blink_cnt;
    w_blink_phase = r_blink_phase;
    if (is_blink(w_next) && !is_blink(r_state)) begin
      w_blink_cnt   = {BLINK_W{1'b0}};
      w_blink_phase = 1'b1;
    end else if (is_blink(w_next)) begin
      if (r_blink_cnt == BLINK_LAST) begin
        w_blink_cnt   = {BLINK_W{1'b0}};
        w_blink_phase = ~r_blink_phase;
      end else begin
        w_blink_cnt   = r_blink_cnt + BLINK_W'(1);
        w_blink_phase = r_blink_phase;
      end
    end else begin
      w_blink_cnt   = r_blink_cnt;
      w_blink_phase = r_blink_phase;
    end
  end

  // State, timers and outputs; outputs decode the incoming state so they move with it.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_state       <= S_INIT;
      r_warn_cnt    <= {WARN_W{1'b0}};
      r_travel_cnt  <= {TRAVEL_W{1'b0}};
      r_blink_cnt   <= {BLINK_W{1'b0}};
      r_blink_phase <= 1'b0;
      motor_down    <= 1'b0;
      motor_up      <= 1'b0;
      warn_lamp     <= 1'b0;
      gate_closed   <= 1'b0;
      gate_open     <= 1'b0;
      fault         <= 1'b0;
    end else begin
      r_state <= w_next;

      if ((w_next == S_WARN) && (r_state != S_WARN)) begin
        r_warn_cnt <= {WARN_W{1'b0}};
      end else if (r_state == S_WARN) begin
        r_warn_cnt <= r_warn_cnt + WARN_W'(1);
      end else begin
        r_warn_cnt <= r_warn_cnt;
      end

      if (((w_next == S_LOWERING) && (r_state != S_LOWERING)) ||
          ((w_next == S_RAISING) && (r_state != S_RAISING))) begin
        r_travel_cnt <= {TRAVEL_W{1'b0}};
      end else if ((r_state == S_LOWERING) || (r_state == S_RAISING)) begin
        r_travel_cnt <= r_travel_cnt + TRAVEL_W'(1);
      end else begin
        r_travel_cnt <= r_travel_cnt;
      end

      r_blink_cnt   <= w_blink_cnt;
      r_blink_phase <= w_blink_phase;

      motor_down  <= (w_next == S_LOWERING);
      motor_up    <= (w_next == S_RAISING);
      gate_closed <= (w_next == S_CLOSED);
      gate_open   <= (w_next == S_OPEN);
      fault       <= (w_next == S_FAULT);
      warn_lamp   <= (w_next == S_FAULT) || (is_blink(w_next) && w_blink_phase);
    end
  end

endmodule

// File: tb/tb_gate_actuator_ctrl.sv
// Bench for gate_actuator_ctrl: directed crossing scenarios followed by random pin
// activity, every cycle compared against a timestamp-based behavioural model.
module tb_gate_actuator_ctrl;

  localparam int WARN_CYCLES    = 20;
  localparam int TRAVEL_TIMEOUT = 50;
  localparam int BLINK_HALF     = 4;

  localparam int G_INIT   = 0;
  localparam int G_OPEN   = 1;
  localparam int G_WARN   = 2;
  localparam int G_LOWER  = 3;
  localparam int G_CLOSED = 4;
  localparam int G_RAISE  = 5;
  localparam int G_REV    = 6;
  localparam int G_FAULT  = 7;

  logic clk;
  logic reset;
  logic close_req;
  logic limit_down;
  logic limit_up;
  logic motor_down;
  logic motor_up;
  logic warn_lamp;
  logic gate_closed;
  logic gate_open;
  logic fault;

  gate_actuator_ctrl #(
    .WARN_CYCLES    (WARN_CYCLES),
    .TRAVEL_TIMEOUT (TRAVEL_TIMEOUT),
    .BLINK_HALF     (BLINK_HALF)
  ) dut (
    .clk_100MHz  (clk),
    .reset       (reset),
    .close_req   (close_req),
    .limit_down  (limit_down),
    .limit_up    (limit_up),
    .motor_down  (motor_down),
    .motor_up    (motor_up),
    .warn_lamp   (warn_lamp),
    .gate_closed (gate_closed),
    .gate_open   (gate_open),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  int cyc;
  int m_mode;
  int t_enter;
  int blink_t0;
  bit q_c[$];
  bit q_d[$];
  bit q_u[$];

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit lamp_mode(input int m);
    return (m == G_WARN) || (m == G_LOWER) || (m == G_CLOSED) ||
           (m == G_RAISE) || (m == G_REV);
  endfunction

  // Reference: decisions see the pin level from two edges back; timing via timestamps.
  task automatic model_step();
    bit c, d, u;
    int nxt, el;
    q_c.push_back(close_req);
    q_d.push_back(limit_down);
    q_u.push_back(limit_up);
    if (q_c.size() > 3) void'(q_c.pop_front());
    if (q_d.size() > 3) void'(q_d.pop_front());
    if (q_u.size() > 3) void'(q_u.pop_front());
    cyc++;
    if (reset) begin
      m_mode  = G_INIT;
      t_enter = cyc;
      return;
    end
    c   = q_c[0];
    d   = q_d[0];
    u   = q_u[0];
    el  = cyc - t_enter;
    nxt = m_mode;
    if (m_mode != G_INIT && u && d) nxt = G_FAULT;
    else if (m_mode == G_INIT) nxt = u ? G_OPEN : G_RAISE;
    else if (m_mode == G_OPEN) nxt = c ? G_WARN : G_OPEN;
    else if (m_mode == G_WARN) nxt = !c ? G_OPEN : (el == WARN_CYCLES) ? G_LOWER : G_WARN;
    else if (m_mode == G_LOWER) nxt = d ? G_CLOSED : (el == TRAVEL_TIMEOUT) ? G_FAULT : G_LOWER;
    else if (m_mode == G_CLOSED) nxt = c ? G_CLOSED : G_RAISE;
    else if (m_mode == G_RAISE) nxt = c ? G_REV : u ? G_OPEN : (el == TRAVEL_TIMEOUT) ? G_FAULT : G_RAISE;
    else if (m_mode == G_REV) nxt = G_LOWER;
    if (nxt != m_mode) begin
      if (lamp_mode(nxt) && !lamp_mode(m_mode)) blink_t0 = cyc;
      t_enter = cyc;
      m_mode  = nxt;
    end
  endtask

  task automatic cycle();
    int e_lamp;
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (m_mode == G_FAULT) e_lamp = 1;
    else if (lamp_mode(m_mode)) e_lamp = (((cyc - blink_t0) / BLINK_HALF) % 2 == 0) ? 1 : 0;
    else e_lamp = 0;
    check_eq("motor_down", int'(motor_down), int'(m_mode == G_LOWER));
    check_eq("motor_up", int'(motor_up), int'(m_mode == G_RAISE));
    check_eq("gate_open", int'(gate_open), int'(m_mode == G_OPEN));
    check_eq("gate_closed", int'(gate_closed), int'(m_mode == G_CLOSED));
    check_eq("fault", int'(fault), int'(m_mode == G_FAULT));
    check_eq("warn_lamp", int'(warn_lamp), e_lamp);
    check_eq("interlock", int'(motor_down & motor_up), 0);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  function automatic logic pick(input int sel);
    if (sel == 0) return motor_down;
    else if (sel == 1) return motor_up;
    else return fault;
  endfunction

  // Advance until the selected output reaches the wanted level or the budget runs out.
  task automatic count_until(input int sel, input logic want, input int limit, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while ((pick(sel) !== want) && (n < limit));
  endtask

  initial begin
    int n;
    int r;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    m_mode   = G_INIT;
    t_enter  = 0;
    blink_t0 = 0;
    repeat (2) begin
      q_c.push_back(1'b0);
      q_d.push_back(1'b0);
      q_u.push_back(1'b0);
    end
    reset      = 1'b1;
    close_req  = 1'b0;
    limit_down = 1'b0;
    limit_up   = 1'b1;
    run(4);
    check_eq("reset_state", int'({motor_down, motor_up, warn_lamp, gate_closed, gate_open, fault}), 0);

    // 1: normal close/open cycle
    reset = 1'b0;
    run(6);
    check_eq("t1_open", int'(gate_open), 1);
    close_req = 1'b1;
    count_until(0, 1'b1, 100, n);
    check_eq("t1_req_to_motor_down", n, 3 + WARN_CYCLES);
    limit_up = 1'b0;
    run(29);
    limit_down = 1'b1;
    run(6);
    check_eq("t1_closed", int'(gate_closed), 1);
    check_eq("t1_motor_off", int'(motor_down), 0);
    close_req = 1'b0;
    run(6);
    check_eq("t1_raising", int'(motor_up), 1);
    limit_down = 1'b0;
    run(15);
    limit_up = 1'b1;
    run(6);
    check_eq("t1_reopened", int'(gate_open), 1);

    // 2: abort during warning
    close_req = 1'b1;
    run(13);
    close_req = 1'b0;
    run(8);
    check_eq("t2_abort_open", int'(gate_open), 1);

    // 3: reversal while raising
    close_req = 1'b1;
    count_until(0, 1'b1, 100, n);
    check_eq("t3_req_to_motor_down", n, 3 + WARN_CYCLES);
    limit_up = 1'b0;
    run(10);
    limit_down = 1'b1;
    run(6);
    close_req = 1'b0;
    run(5);
    limit_down = 1'b0;
    run(4);
    close_req = 1'b1;
    count_until(1, 1'b0, 20, n);
    check_eq("t3_reverse_latency", n, 3);
    check_eq("t3_dead_cycle", int'(motor_down), 0);
    cycle();
    check_eq("t3_relower", int'(motor_down), 1);
    run(5);
    limit_down = 1'b1;
    run(6);
    check_eq("t3_closed", int'(gate_closed), 1);

    // 4: lowering timeout
    close_req = 1'b0;
    run(5);
    limit_down = 1'b0;
    run(5);
    limit_up = 1'b1;
    run(6);
    check_eq("t4_open", int'(gate_open), 1);
    close_req = 1'b1;
    count_until(0, 1'b1, 100, n);
    limit_up = 1'b0;
    count_until(2, 1'b1, 100, n);
    check_eq("t4_timeout", n, TRAVEL_TIMEOUT);
    check_eq("t4_motors_off", int'({motor_down, motor_up}), 0);
    check_eq("t4_lamp_on", int'(warn_lamp), 1);
    close_req = 1'b0;
    run(10);
    check_eq("t4_fault_sticky", int'(fault), 1);
    check_eq("t4_lamp_steady", int'(warn_lamp), 1);

    // 5: limit conflict while open
    reset    = 1'b1;
    limit_up = 1'b1;
    run(3);
    reset = 1'b0;
    run(6);
    check_eq("t5_open", int'(gate_open), 1);
    limit_down = 1'b1;
    count_until(2, 1'b1, 20, n);
    check_eq("t5_conflict_latency", n, 3);

    // 6: reset mid-travel
    reset      = 1'b1;
    limit_down = 1'b0;
    run(3);
    reset = 1'b0;
    run(6);
    close_req = 1'b1;
    count_until(0, 1'b1, 100, n);
    limit_up = 1'b0;
    run(5);
    check_eq("t6_lowering", int'(motor_down), 1);
    reset     = 1'b1;
    close_req = 1'b0;
    cycle();
    check_eq("t6_reset_outputs", int'({motor_down, motor_up, warn_lamp, gate_closed, gate_open, fault}), 0);
    run(2);
    reset = 1'b0;
    run(2);
    check_eq("t6_raising_after_reset", int'(motor_up), 1);

    // random pin activity with mostly consistent limit switches
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        run($urandom_range(1, 3));
        reset = 1'b0;
      end
      if ($urandom_range(0, 19) == 0) close_req = ~close_req;
      if ($urandom_range(0, 24) == 0) begin
        r = $urandom_range(0, 99);
        if (r < 40) begin
          limit_up = 1'b1; limit_down = 1'b0;
        end else if (r < 80) begin
          limit_up = 1'b0; limit_down = 1'b1;
        end else if (r < 97) begin
          limit_up = 1'b0; limit_down = 1'b0;
        end else begin
          limit_up = 1'b1; limit_down = 1'b1;
        end
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
